// File: rtl/core_ctrl.sv
// core_ctrl: sequences one attention-core pass (fill, preload, execute, drain, xfer, acc, sync, divide).
// Latency: first command appears the cycle after start is sampled; every output is a flop.
// Backpressure: the only stall is SYNC, held until the partner core's sum FIFO reports non-empty.
module core_ctrl #(
    parameter int col   = 8,
    parameter int pr    = 8,
    parameter int len   = 8,
    parameter int drain = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sum_rd_vld,
    output logic [19:0] inst,
    output logic        mem_in_rd,
    output logic        mem_in_sel,
    output logic        busy,
    output logic        done
);

    // Row counter is at least 5 bits; widened only if col or drain outgrow it.
    localparam int CW_COL = $clog2(col + 1);
    localparam int CW_DRN = $clog2(drain + 1);
    localparam int CW_MAX = (CW_COL > CW_DRN) ? CW_COL : CW_DRN;
    localparam int CW     = (CW_MAX > 5) ? CW_MAX : 5;

    localparam logic [CW-1:0] LEN_C    = CW'(len);
    localparam logic [CW-1:0] LEN_M1   = CW'(len - 1);
    localparam logic [CW-1:0] COL_C    = CW'(col);
    localparam logic [CW-1:0] COL_M1   = CW'(col - 1);
    localparam logic [CW-1:0] DRAIN_M1 = CW'(drain - 1);

    // Array row parallelism has no effect on the command stream.
    if (pr < 1) begin : g_pr_unused
    end

    typedef struct packed {
        logic       sfp_pmem_wr;
        logic       acc;
        logic       div;
        logic       ofifo_rd;
        logic [3:0] qkmem_add;
        logic [3:0] pmem_add;
        logic       execute;
        logic       load;
        logic       qmem_rd;
        logic       qmem_wr;
        logic       kmem_rd;
        logic       kmem_wr;
        logic       pmem_rd;
        logic       pmem_wr;
    } inst_t;

    typedef enum logic [3:0] {
        IDLE,
        QWR,
        KWR,
        KLOAD,
        EXEC,
        DRAIN,
        XFER,
        ACC,
        SYNC,
        DIV_RD,
        DIV_WR,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    inst_t         inst_nxt;
    logic          mem_in_rd_nxt;
    logic          mem_in_sel_nxt;
    logic          busy_nxt;
    logic          done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            inst       <= '0;
            mem_in_rd  <= 1'b0;
            mem_in_sel <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            inst       <= inst_nxt;
            mem_in_rd  <= mem_in_rd_nxt;
            mem_in_sel <= mem_in_sel_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    // Next state and counter; the counter clears whenever a new phase is entered.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    state_nxt = QWR;
                end
            end
            QWR: begin
                if (cnt == LEN_M1) begin
                    state_nxt = KWR;
                    cnt_nxt   = '0;
                end
            end
            KWR: begin
                if (cnt == COL_M1) begin
                    state_nxt = KLOAD;
                    cnt_nxt   = '0;
                end
            end
            KLOAD: begin
                if (cnt == COL_C) begin
                    state_nxt = EXEC;
                    cnt_nxt   = '0;
                end
            end
            EXEC: begin
                if (cnt == LEN_C) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_M1) begin
                    state_nxt = XFER;
                    cnt_nxt   = '0;
                end
            end
            XFER: begin
                if (cnt == LEN_M1) begin
                    state_nxt = ACC;
                    cnt_nxt   = '0;
                end
            end
            ACC: begin
                if (cnt == LEN_C) begin
                    state_nxt = SYNC;
                    cnt_nxt   = '0;
                end
            end
            SYNC: begin
                cnt_nxt = '0;
                if (sum_rd_vld) begin
                    state_nxt = DIV_RD;
                end
            end
            DIV_RD: begin
                cnt_nxt   = cnt;
                state_nxt = DIV_WR;
            end
            DIV_WR: begin
                if (cnt >= LEN_M1) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = DIV_RD;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Commands are decoded from the upcoming state so they land in flops aligned with it.
    always_comb begin
        inst_nxt       = '0;
        mem_in_rd_nxt  = 1'b0;
        mem_in_sel_nxt = 1'b0;
        done_nxt       = 1'b0;
        busy_nxt       = (state_nxt != IDLE);
        case (state_nxt)
            QWR: begin
                inst_nxt.qmem_wr   = 1'b1;
                inst_nxt.qkmem_add = cnt_nxt[3:0];
                mem_in_rd_nxt      = 1'b1;
            end
            KWR: begin
                inst_nxt.kmem_wr   = 1'b1;
                inst_nxt.qkmem_add = cnt_nxt[3:0];
                mem_in_rd_nxt      = 1'b1;
                mem_in_sel_nxt     = 1'b1;
            end
            KLOAD: begin
                inst_nxt.load = 1'b1;
                if (cnt_nxt < COL_C) begin
                    inst_nxt.kmem_rd   = 1'b1;
                    inst_nxt.qkmem_add = cnt_nxt[3:0];
                end
            end
            EXEC: begin
                inst_nxt.execute = 1'b1;
                if (cnt_nxt < LEN_C) begin
                    inst_nxt.qmem_rd   = 1'b1;
                    inst_nxt.qkmem_add = cnt_nxt[3:0];
                end
            end
            XFER: begin
                inst_nxt.ofifo_rd = 1'b1;
                inst_nxt.pmem_wr  = 1'b1;
                inst_nxt.pmem_add = cnt_nxt[3:0];
            end
            ACC: begin
                inst_nxt.acc = 1'b1;
                if (cnt_nxt < LEN_C) begin
                    inst_nxt.pmem_rd  = 1'b1;
                    inst_nxt.pmem_add = cnt_nxt[3:0];
                end
            end
            DIV_RD: begin
                inst_nxt.div      = 1'b1;
                inst_nxt.pmem_rd  = 1'b1;
                inst_nxt.pmem_add = cnt_nxt[3:0];
            end
            DIV_WR: begin
                inst_nxt.sfp_pmem_wr = 1'b1;
                inst_nxt.pmem_wr     = 1'b1;
                inst_nxt.pmem_add    = cnt_nxt[3:0];
            end
            DONE: begin
                done_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: two instances (defaults, and len=16/drain=1) checked cycle by cycle
// against a phase-list model of the pass, with random sync stalls and start/sum_rd_vld noise.
`timescale 1ns/1ps
module tb_core_ctrl;
    localparam int COL     = 8;
    localparam int LEN_A   = 8;
    localparam int DRAIN_A = 16;
    localparam int LEN_B   = 16;
    localparam int DRAIN_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, start_a, vld_a;
    logic        reset_b, start_b, vld_b;
    logic [19:0] inst_a, inst_b;
    logic        rd_a, sel_a, busy_a, done_a;
    logic        rd_b, sel_b, busy_b, done_b;

    core_ctrl #(.col(COL), .pr(8), .len(LEN_A), .drain(DRAIN_A)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .sum_rd_vld(vld_a),
        .inst(inst_a), .mem_in_rd(rd_a), .mem_in_sel(sel_a), .busy(busy_a), .done(done_a)
    );

    core_ctrl #(.col(COL), .pr(8), .len(LEN_B), .drain(DRAIN_B)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .sum_rd_vld(vld_b),
        .inst(inst_b), .mem_in_rd(rd_b), .mem_in_sel(sel_b), .busy(busy_b), .done(done_b)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [21:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit rd, input bit sel, input int v);
        exp_q.push_back({rd, sel, 20'(v)});
    endtask

    // Expected command list of one pass, phase by phase, with s SYNC cycles.
    task automatic build(input int ln, input int dr, input int s);
        exp_q.delete();
        for (int r = 0; r < ln; r++)   push(1, 0, 'h10 | (r << 12));
        for (int r = 0; r < COL; r++)  push(1, 1, 'h4 | (r << 12));
        for (int r = 0; r <= COL; r++) push(0, 0, 'h40 | ((r < COL) ? ('h8 | (r << 12)) : 0));
        for (int r = 0; r <= ln; r++)  push(0, 0, 'h80 | ((r < ln) ? ('h20 | (r << 12)) : 0));
        for (int r = 0; r < dr; r++)   push(0, 0, 0);
        for (int r = 0; r < ln; r++)   push(0, 0, 'h10001 | (r << 8));
        for (int r = 0; r <= ln; r++)  push(0, 0, 'h40000 | ((r < ln) ? ('h2 | (r << 8)) : 0));
        for (int r = 0; r < s; r++)    push(0, 0, 0);
        for (int r = 0; r < ln; r++) begin
            push(0, 0, 'h20002 | (r << 8));
            push(0, 0, 'h80001 | (r << 8));
        end
    endtask

    task automatic drive(input bit which, input logic st, input logic vl, input logic rs);
        if (which) begin
            start_b = st; vld_b = vl; reset_b = rs;
        end else begin
            start_a = st; vld_a = vl; reset_a = rs;
        end
    endtask

    task automatic sample(input bit which, output logic [19:0] oi, output logic ord,
                          output logic osel, output logic obusy, output logic odone);
        oi    = which ? inst_b : inst_a;
        ord   = which ? rd_b   : rd_a;
        osel  = which ? sel_b  : sel_a;
        obusy = which ? busy_b : busy_a;
        odone = which ? done_b : done_a;
    endtask

    task automatic chk_idle(input bit which, input string tag);
        logic [19:0] oi;
        logic        ord, osel, obusy, odone;
        sample(which, oi, ord, osel, obusy, odone);
        chk({tag, "_inst"}, 32'(oi), 32'h0);
        chk({tag, "_mem_in"}, 32'({ord, osel}), 32'h0);
        chk({tag, "_busy"}, 32'(obusy), 32'h0);
        chk({tag, "_done"}, 32'(odone), 32'h0);
    endtask

    // mode 0: start quiet; 1: random start noise; 2: start pulse in EXEC, then held through DONE.
    task automatic run_pass(input bit which, input int s, input int abort_at, input int mode);
        int          ln, dr, n, sync0, pulse_at;
        logic [19:0] oi;
        logic        ord, osel, obusy, odone;
        ln = which ? LEN_B : LEN_A;
        dr = which ? DRAIN_B : DRAIN_A;
        build(ln, dr, s);
        n        = exp_q.size();
        sync0    = 4 * ln + 2 * COL + dr + 3;
        pulse_at = ln + 2 * COL + 1 + $urandom_range(0, ln);
        drive(which, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            logic st;
            logic vl;
            case (mode)
                1:       st = 1'($urandom_range(0, 1));
                2:       st = (i == pulse_at) || (i >= n - 3);
                default: st = 1'b0;
            endcase
            if (i < sync0 || i >= sync0 + s) vl = 1'($urandom_range(0, 1));
            else                             vl = (i == sync0 + s - 1);
            drive(which, st, vl, i == abort_at);
            sample(which, oi, ord, osel, obusy, odone);
            chk("inst", 32'(oi), 32'(exp_q[i][19:0]));
            chk("mem_in_rd_sel", 32'({ord, osel}), 32'(exp_q[i][21:20]));
            chk("busy", 32'(obusy), 32'h1);
            chk("done", 32'(odone), 32'h0);
            chk("pmem_rd_and_wr", 32'(oi[1] & oi[0]), 32'h0);
            @(negedge clk);
            if (i == abort_at) begin
                chk_idle(which, "after_reset");
                drive(which, 1'b0, 1'b0, 1'b0);
                return;
            end
        end
        drive(which, (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        sample(which, oi, ord, osel, obusy, odone);
        chk("done_inst", 32'(oi), 32'h0);
        chk("done_mem_in", 32'({ord, osel}), 32'h0);
        chk("done_busy", 32'(obusy), 32'h1);
        chk("done_pulse", 32'(odone), 32'h1);
        @(negedge clk);
        drive(which, mode == 2, 1'b0, 1'b0);
        chk_idle(which, "post_done");
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk_idle(0, "reset_a");
        chk_idle(1, "reset_b");
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        run_pass(0, 1, -1, 0);
        run_pass(0, 21, -1, 1);
        run_pass(0, 1, 2 * LEN_A + 2 * COL + 2 + DRAIN_A + 2, 0);
        run_pass(0, $urandom_range(1, 4), -1, 0);
        run_pass(0, 3, -1, 2);
        run_pass(0, $urandom_range(1, 8), -1, 1);
        run_pass(1, 1, -1, 0);
        run_pass(1, $urandom_range(1, 8), -1, 1);
        for (int k = 0; k < 3; k++) begin
            run_pass(0, $urandom_range(1, 6), -1, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
